// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Sequences one 32-bit word access from the pipeline memory stage into two
// consecutive 16-bit accesses on a synchronous external SRAM, low half first.
// While an access is in flight, ready is held low to freeze the pipeline.
//
// Parameters
//   ADDR_BASE  byte address that maps to SRAM half-word 0
//   SRAM_AW    SRAM half-word address width
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   wr_en       word write request, held until ready
//   rd_en       word read request, held until ready
//   address     word-aligned byte address, stable while a request is held
//   write_data  word to write, stable while wr_en is held
//   read_data   last completed read word
//   ready       high when nothing is pending or the request completes now
//   SRAM_DQ     bidirectional SRAM data bus
//   SRAM_ADDR   SRAM half-word address
//   SRAM_WE_N   SRAM write enable, active-low
// -----------------------------------------------------------------------------
module sram_controller #(
    parameter int unsigned ADDR_BASE = 1024,
    parameter int unsigned SRAM_AW   = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N
);

    localparam int unsigned IDX_W = SRAM_AW - 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] W_LO   = 3'd1;
    localparam logic [2:0] W_HI   = 3'd2;
    localparam logic [2:0] R_LO   = 3'd3;
    localparam logic [2:0] R_HI   = 3'd4;
    localparam logic [2:0] R_WAIT = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [IDX_W-1:0]   idx_in;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [SRAM_AW-1:0] addr_hold;
    logic               dq_drive;
    logic [15:0]        dq_out;

    // Word index relative to the base; the cast truncates so addresses
    // outside the SRAM window simply wrap.
    assign idx_in = IDX_W'((address - ADDR_BASE) >> 2);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_en)      state_nxt = W_LO;
                else if (rd_en) state_nxt = R_LO;
            end
            W_LO:    state_nxt = W_HI;
            W_HI:    state_nxt = DONE;
            R_LO:    state_nxt = R_HI;
            R_HI:    state_nxt = R_WAIT;
            R_WAIT:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Request operands are captured only on acceptance; later changes on the
    // pipeline side are ignored until the sequence finishes.
    always_ff @(posedge clk) begin
        if (state == IDLE && (wr_en || rd_en)) begin
            idx_q <= idx_in;
            if (wr_en) wdata_q <= write_data;
        end
    end

    // Outside access states the bus address keeps whatever was last presented.
    always_comb begin
        case (state)
            W_LO, R_LO: SRAM_ADDR = {idx_q, 1'b0};
            W_HI, R_HI: SRAM_ADDR = {idx_q, 1'b1};
            default:    SRAM_ADDR = addr_hold;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) addr_hold <= '0;
        else      addr_hold <= SRAM_ADDR;
    end

    assign dq_drive  = (state == W_LO) || (state == W_HI);
    assign dq_out    = (state == W_HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ   = dq_drive ? dq_out : 16'bz;
    assign SRAM_WE_N = ~dq_drive;

    assign ready = ~(wr_en | rd_en) | (state == DONE);

    // The SRAM returns registered data one cycle after the address, so the
    // low half is on the bus during R_HI and the high half during R_WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else if (state == R_HI) begin
            read_data[15:0] <= SRAM_DQ;
        end else if (state == R_WAIT) begin
            read_data[31:16] <= SRAM_DQ;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
// Bench for sram_controller: a synchronous SRAM model on the bus, a word-level
// reference memory, per-cycle expectations derived from the access timeline,
// directed cases followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_sram_controller;

    localparam int unsigned ADDR_BASE = 1024;
    localparam int unsigned SRAM_AW   = 18;
    localparam int unsigned NWORDS    = 1 << (SRAM_AW - 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wr_en;
    logic               rd_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    wire  [15:0]        sram_dq;
    logic [SRAM_AW-1:0] sram_addr;
    logic               sram_we_n;

    sram_controller #(.ADDR_BASE(ADDR_BASE), .SRAM_AW(SRAM_AW)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .ready     (ready),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n)
    );

    always #5 clk = ~clk;

    // External synchronous SRAM: it drives its registered output only while a
    // read is being requested, so it never fights the controller on writes.
    bit [15:0] sram_mem [0:(1<<SRAM_AW)-1];
    bit [15:0] sram_q;
    bit        sram_oe;

    assign sram_dq = (sram_oe && sram_we_n) ? sram_q : 16'bz;

    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
        else            sram_q <= sram_mem[sram_addr];
        sram_oe <= sram_we_n && rd_en && !wr_en;
    end

    // Word-level reference memory, indexed by word index.
    bit [31:0] ref_mem [int];

    int n_chk  = 0;
    int n_fail = 0;
    int we_low_cnt = 0;

    bit                 chk_en = 1'b0;
    logic               exp_ready;
    logic               exp_we_n;
    logic [SRAM_AW-1:0] exp_addr = '0;
    logic [31:0]        exp_rd = '0;
    logic               exp_dq_drv;
    logic [15:0]        exp_dq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic bus_floating();
        return (sram_dq === 16'bz) || (sram_dq === 16'h0);
    endfunction

    always @(negedge clk) begin
        if (!sram_we_n) we_low_cnt++;
        if (chk_en) begin
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("we_n", 32'(sram_we_n), 32'(exp_we_n));
            chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
            chk("read_data", read_data, exp_rd);
            if (exp_dq_drv)    chk("dq_value", 32'(sram_dq), 32'(exp_dq));
            else if (!sram_oe) chk("dq_float", 32'(bus_floating()), 32'd1);
        end
    end

    function automatic int word_idx(input logic [31:0] a);
        return int'(((a - ADDR_BASE) >> 2) % NWORDS);
    endfunction

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            wr_en = 1'b0; rd_en = 1'b0;
            exp_ready = 1'b1; exp_we_n = 1'b1; exp_dq_drv = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // One word operation. Write: IDLE,W_LO,W_HI,DONE. Read: IDLE,R_LO,R_HI,
    // R_WAIT,DONE. drop_at>0 releases a write request from that cycle on.
    task automatic run_op(input bit is_wr, input bit both, input logic [31:0] a,
                          input logic [31:0] d, input int drop_at);
        int n;
        int idx;
        bit held;
        bit [31:0] word;
        n    = is_wr ? 4 : 5;
        idx  = word_idx(a);
        word = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        address = a; write_data = d;
        for (int c = 0; c < n; c++) begin
            held  = !(is_wr && drop_at > 0 && c >= drop_at);
            wr_en = is_wr && held;
            rd_en = (!is_wr || both) && held;
            exp_ready  = !held || (c == n - 1);
            exp_we_n   = !(is_wr && (c == 1 || c == 2));
            exp_dq_drv = is_wr && (c == 1 || c == 2);
            exp_dq     = (c == 2) ? d[31:16] : d[15:0];
            if (c == 1) exp_addr = SRAM_AW'(2 * idx);
            if (c == 2) exp_addr = SRAM_AW'(2 * idx + 1);
            if (!is_wr && c == 3) exp_rd[15:0] = word[15:0];
            if (!is_wr && c == 4) exp_rd = word;
            @(posedge clk); #1;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        if (is_wr) ref_mem[idx] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pre;
        bit wr;
        logic [31:0] a;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        address = 32'h0; write_data = 32'h0;
        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_we_n", 32'(sram_we_n), 32'd1);
        chk("reset_addr", 32'(sram_addr), 32'd0);
        chk("reset_read_data", read_data, 32'd0);
        chk("reset_dq_float", 32'(bus_floating()), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle_cycles(2);

        // Directed cases.
        pre = we_low_cnt;
        run_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 0);
        chk("sram0", 32'(sram_mem[0]), 32'h0000BEEF);
        chk("sram1", 32'(sram_mem[1]), 32'h0000DEAD);
        chk("we_low_cycles", 32'(we_low_cnt - pre), 32'd2);
        run_op(1'b0, 1'b0, 32'd1024, 32'h0, 0);
        chk("read_1024", read_data, 32'hDEADBEEF);
        idle_cycles(1);
        run_op(1'b1, 1'b0, 32'd1028, 32'h12345678, 0);
        run_op(1'b0, 1'b0, 32'd1028, 32'h0, 0);
        chk("sram2", 32'(sram_mem[2]), 32'h00005678);
        chk("sram3", 32'(sram_mem[3]), 32'h00001234);
        chk("read_1028", read_data, 32'h12345678);
        run_op(1'b1, 1'b1, 32'd1032, 32'hA5A50F0F, 0);
        chk("both_sram4", 32'(sram_mem[4]), 32'h00000F0F);
        chk("both_sram5", 32'(sram_mem[5]), 32'h0000A5A5);
        chk("both_read_data", read_data, 32'h12345678);
        idle_cycles(1);

        // Reset during W_HI: low half already written, high half not.
        chk_en = 1'b0;
        address = 32'd1040; write_data = 32'hCAFEF00D; wr_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstw_ready", 32'(ready), 32'd0);
        chk("rstw_we_n", 32'(sram_we_n), 32'd1);
        chk("rstw_addr", 32'(sram_addr), 32'd0);
        chk("rstw_read_data", read_data, 32'd0);
        chk("rstw_dq_float", 32'(bus_floating()), 32'd1);
        wr_en = 1'b0;
        #1;
        chk("rstw_ready_idle", 32'(ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstw_sram8", 32'(sram_mem[8]), 32'h0000F00D);
        chk("rstw_sram9", 32'(sram_mem[9]), 32'h00000000);
        ref_mem[4] = 32'h0000F00D;
        exp_addr = '0; exp_rd = '0;
        chk_en = 1'b1;
        idle_cycles(1);
        run_op(1'b0, 1'b0, 32'd1024, 32'h0, 0);
        chk("read_after_rst", read_data, 32'hDEADBEEF);
        run_op(1'b0, 1'b0, 32'd1040, 32'h0, 0);
        chk("read_partial", read_data, 32'h0000F00D);

        // Reset during R_WAIT: the captured low half is discarded.
        chk_en = 1'b0;
        address = 32'd1028; rd_en = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("rstr_partial_lo", 32'(read_data[15:0]), 32'h00005678);
        rst_n = 1'b0;
        #1;
        chk("rstr_read_data", read_data, 32'd0);
        rd_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        exp_addr = '0; exp_rd = '0;
        chk_en = 1'b1;
        idle_cycles(1);

        // Randomized traffic, including wrapped addresses and dropped writes.
        for (int i = 0; i < 60; i++) begin
            wr = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0)
                a = ADDR_BASE - 4 * $urandom_range(1, 4);
            else
                a = ADDR_BASE + 4 * $urandom_range(0, 15);
            if (wr)
                run_op(1'b1, $urandom_range(0, 3) == 0, a, $urandom,
                       int'($urandom_range(0, 3)));
            else
                run_op(1'b0, 1'b0, a, 32'h0, 0);
            idle_cycles(int'($urandom_range(0, 2)));
        end
        idle_cycles(2);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
